flash_read_responder: RTL



---
 rtl/flash_resp_pkg.sv | 29 ++
 rtl/resp_delay_pipe.sv | 67 ++++++
 rtl/flash_read_responder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/flash_resp_pkg.sv
// Shared types and constants for the flash read responder.
// Holds the delay-pipe entry type, the byte-lane masking helper and the LFSR constants.
package flash_resp_pkg;

    localparam int          BYTE_LANES   = 4;
    localparam int          ENTRY_ADDR_W = 32;
    localparam logic [31:0] OOB_DATA     = 32'h0000_0000;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [BYTE_LANES-1:0]   be;
    } pipe_entry_t;

    function automatic logic [31:0] lane_mask(input logic [31:0] word,
                                              input logic [BYTE_LANES-1:0] be);
        logic [31:0] masked;
        masked = 32'h0000_0000;
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) begin
                masked[8*i +: 8] = word[8*i +: 8];
            end
        end
        return masked;
    endfunction

endpackage

// File: rtl/resp_delay_pipe.sv
// Delay pipe of accepted read commands plus the outstanding-read counter.
// The final latency stage is the top level's output register, so only DEPTH-1 stages live here.
module resp_delay_pipe
    import flash_resp_pkg::*;
#(
    parameter int DEPTH       = 2,
    parameter int MAX_PENDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  pipe_entry_t entry_i,
    input  logic        retire_i,
    output pipe_entry_t tail_o,
    output logic        full_o
);

    localparam int CNT_W = $clog2(MAX_PENDING + 1);

    logic [CNT_W-1:0] pending_q;
    logic [CNT_W-1:0] pending_d;

    generate
        if (DEPTH == 1) begin : g_direct
            assign tail_o = entry_i;
        end else begin : g_stages
            pipe_entry_t stage_q [DEPTH-1];

            // Shift register of in-flight commands
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= entry_i;
                    for (int i = 1; i < DEPTH - 1; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign tail_o = stage_q[DEPTH-2];
        end
    endgenerate

    // Retirement is the readDataValid cycle; a simultaneous accept keeps the count
    always_comb begin
        pending_d = pending_q;
        case ({entry_i.valid, retire_i})
            2'b10:   pending_d = pending_q + CNT_W'(1);
            2'b01:   pending_d = pending_q - CNT_W'(1);
            default: pending_d = pending_q;
        endcase
    end

    // Outstanding-read counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign full_o = (pending_q == CNT_W'(MAX_PENDING)) & ~retire_i;

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM read-only flash stand-in with wait states, fixed latency and bounded outstanding reads.
// Define RANDOM_WAIT_EN to draw each command's wait target from a 16-bit LFSR.
module flash_read_responder
    import flash_resp_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 32,
    parameter int MEM_WORDS    = 1024,
    parameter int WAIT_CYCLES  = 0,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [3:0]        byteEnable,
    output logic              waitRequest,
    output logic [DATA_W-1:0] readData,
    output logic              readDataValid,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              oob_error
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [3:0]        wcnt_q, wcnt_d, target_s;
    logic              full_s, wait_s, accept_s;
    pipe_entry_t       entry_s, tail_s;
    logic              rdv_q, rdv_d, oob_q, oob_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef RANDOM_WAIT_EN
    logic [15:0] lfsr_q;
    logic [3:0]  target_q;
    logic        active_q;

    // Free-running Galois LFSR plus the target latched for the current command
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q   <= LFSR_SEED;
            target_q <= 4'd0;
            active_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ LFSR_TAPS) : {1'b0, lfsr_q[15:1]};
            target_q <= target_s;
            active_q <= read & ~accept_s;
        end
    end

    assign target_s = active_q ? target_q
                               : 4'({1'b0, lfsr_q[3:0]} % 5'(WAIT_CYCLES + 1));
`else
    assign target_s = 4'(WAIT_CYCLES);
`endif

    assign wait_s      = read & ((wcnt_q < target_s) | full_s);
    assign accept_s    = read & ~wait_s;
    assign waitRequest = wait_s;

    // Wait counter: counts only unblocked stall cycles, cleared on accept or withdrawal
    always_comb begin
        wcnt_d = wcnt_q;
        if (!read || accept_s) begin
            wcnt_d = 4'd0;
        end else if (wait_s && !full_s && (wcnt_q < target_s)) begin
            wcnt_d = wcnt_q + 4'd1;
        end else begin
            wcnt_d = wcnt_q;
        end
    end

    always_comb begin
        entry_s       = '0;
        entry_s.valid = accept_s;
        entry_s.addr  = ENTRY_ADDR_W'(address);
        entry_s.be    = byteEnable;
    end

    resp_delay_pipe #(
        .DEPTH       (READ_LATENCY),
        .MAX_PENDING (MAX_PENDING)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .entry_i  (entry_s),
        .retire_i (rdv_q),
        .tail_o   (tail_s),
        .full_o   (full_s)
    );

    // Last latency stage: fetch, lane-mask and range-check the word leaving the pipe
    always_comb begin
        rdv_d   = tail_s.valid;
        rdata_d = rdata_q;
        oob_d   = oob_q;
        if (tail_s.valid) begin
            if (tail_s.addr >= ENTRY_ADDR_W'(MEM_WORDS)) begin
                rdata_d = OOB_DATA;
                oob_d   = 1'b1;
            end else begin
                rdata_d = lane_mask(mem[tail_s.addr[IDX_W-1:0]], tail_s.be);
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Output and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt_q  <= 4'd0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
            oob_q   <= oob_d;
        end
    end

    // Backdoor preload; not reset, and a same-edge fetch sees the old word
    always_ff @(posedge clk) begin
        if (load_en && (32'(load_addr) < 32'(MEM_WORDS))) begin
            mem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    assign readDataValid = rdv_q;
    assign readData      = rdata_q;
    assign oob_error     = oob_q;

endmodule
